// File: rtl/tf_filter_pkg.sv
// rtl/tf_filter_pkg.sv - shared types and fixed-point helpers for the TDM IIR filter
package tf_filter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC_Y, ST_CALC_S, ST_DONE} state_t;

  localparam int RS_W = 128;

  function automatic int acc_w(input int width, input int cw);
    return width + cw + 2;
  endfunction

  // Optional round-half-up right shift by frac, then clamp to a signed field of 'width' bits.
  function automatic logic signed [RS_W-1:0] round_sat(input logic signed [RS_W-1:0] v,
                                                        input int frac, input int width);
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] lim;
    r = v;
    if (frac > 0) r = (v + (RS_W'(1) <<< (frac - 1))) >>> frac;
    lim = RS_W'(1) <<< (width - 1);
    if (r > lim - RS_W'(1)) r = lim - RS_W'(1);
    else if (r < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/tf_filter_tdm_mac.sv
// rtl/tf_filter_tdm_mac.sv - combinational b*x - a*y + s with accumulator saturation
module tf_mac
  import tf_filter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 18,
  parameter int ACC_W = 36
) (
  input  logic signed [CW-1:0]    b,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [CW-1:0]    a,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [ACC_W-1:0] s,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PW = WIDTH + CW;
  localparam int SW = ACC_W + 2;

  logic signed [PW-1:0] bx;
  logic signed [PW-1:0] ay;
  logic signed [SW-1:0] sum;

  always_comb begin
    bx  = PW'(b) * PW'(x);
    ay  = PW'(a) * PW'(y);
    sum = SW'(bx) - SW'(ay) + SW'(s);
    acc = ACC_W'(round_sat(RS_W'(sum), 0, ACC_W));
  end

endmodule

// File: rtl/tf_filter_tdm.sv
// rtl/tf_filter_tdm.sv - multichannel DF2T IIR filter sharing one MAC across channels
module tf_filter_tdm
  import tf_filter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 18,
  parameter int CF    = 16,
  parameter int ORDER = 2,
  parameter int N_CH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CH*WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_CH*WIDTH-1:0]      out_data,
  input  logic                       coef_we,
  input  logic [$clog2(2*ORDER+1)-1:0] coef_addr,
  input  logic signed [CW-1:0]       coef_data,
  input  logic                       clear_state
);

  localparam int ACC_W = acc_w(WIDTH, CW);
  localparam int NC    = 2 * ORDER + 1;
  localparam int AW    = $clog2(NC);
  localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int KW    = $clog2(ORDER + 1);

  state_t                   state_q, state_d;
  logic [CHW-1:0]           ch_q, ch_d;
  logic [KW-1:0]            k_q, k_d;
  logic [N_CH*WIDTH-1:0]    x_q, x_d;
  logic signed [WIDTH-1:0]  yv_q, yv_d;
  logic [N_CH*WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [CW-1:0]     coef_sh_q [NC];
  logic signed [CW-1:0]     coef_sh_d [NC];
  logic signed [CW-1:0]     coef_act_q [NC];
  logic signed [CW-1:0]     coef_act_d [NC];
  logic signed [ACC_W-1:0]  s_q [N_CH][ORDER];
  logic signed [ACC_W-1:0]  s_d [N_CH][ORDER];

  logic signed [WIDTH-1:0]  x_cur, mac_y, y_new;
  logic signed [CW-1:0]     mac_b, mac_a;
  logic signed [ACC_W-1:0]  mac_s, mac_acc;

  tf_mac #(.WIDTH(WIDTH), .CW(CW), .ACC_W(ACC_W)) u_mac (
    .b(mac_b), .x(x_cur), .a(mac_a), .y(mac_y), .s(mac_s), .acc(mac_acc)
  );

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    k_d         = k_q;
    x_d         = x_q;
    yv_d        = yv_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    coef_sh_d   = coef_sh_q;
    coef_act_d  = coef_act_q;
    s_d         = s_q;
    x_cur       = '0;
    mac_b       = '0;
    mac_a       = '0;
    mac_y       = '0;
    mac_s       = '0;

    for (int c = 0; c < N_CH; c++)
      if (ch_q == CHW'(c)) x_cur = x_q[c*WIDTH +: WIDTH];

    // The MAC computes y in CALC_Y (a=0) and s_k in CALC_S; s_(ORDER+1) is implicitly zero.
    if (state_q == ST_CALC_Y) begin
      mac_b = coef_act_q[0];
      for (int c = 0; c < N_CH; c++)
        if (ch_q == CHW'(c)) mac_s = s_q[c][0];
    end else begin
      mac_y = yv_q;
      for (int k = 1; k <= ORDER; k++)
        if (k_q == KW'(k)) begin
          mac_b = coef_act_q[k];
          mac_a = coef_act_q[ORDER+k];
        end
      for (int k = 1; k < ORDER; k++)
        for (int c = 0; c < N_CH; c++)
          if (k_q == KW'(k) && ch_q == CHW'(c)) mac_s = s_q[c][k];
    end

    y_new = WIDTH'(round_sat(RS_W'(mac_acc), CF, WIDTH));

    case (state_q)
      ST_IDLE: begin
        if (clear_state)
          for (int c = 0; c < N_CH; c++)
            for (int k = 0; k < ORDER; k++) s_d[c][k] = '0;
        if (in_valid) begin
          x_d        = in_data;
          coef_act_d = coef_sh_q;
          ch_d       = '0;
          k_d        = KW'(1);
          state_d    = ST_CALC_Y;
        end
      end
      ST_CALC_Y: begin
        yv_d = y_new;
        for (int c = 0; c < N_CH; c++)
          if (ch_q == CHW'(c)) out_data_d[c*WIDTH +: WIDTH] = y_new;
        k_d     = KW'(1);
        state_d = ST_CALC_S;
      end
      ST_CALC_S: begin
        for (int k = 1; k <= ORDER; k++)
          for (int c = 0; c < N_CH; c++)
            if (k_q == KW'(k) && ch_q == CHW'(c)) s_d[c][k-1] = mac_acc;
        if (k_q == KW'(ORDER)) begin
          if (ch_q == CHW'(N_CH - 1)) begin
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            ch_d    = ch_q + CHW'(1);
            state_d = ST_CALC_Y;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shadow writes land after the accept copy above, so a same-cycle write waits a frame.
    if (coef_we)
      for (int i = 0; i < NC; i++)
        if (coef_addr == AW'(i)) coef_sh_d[i] = coef_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      k_q         <= '0;
      x_q         <= '0;
      yv_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        coef_sh_q[i]  <= '0;
        coef_act_q[i] <= '0;
      end
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < ORDER; k++) s_q[c][k] <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      k_q         <= k_d;
      x_q         <= x_d;
      yv_q        <= yv_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      coef_sh_q   <= coef_sh_d;
      coef_act_q  <= coef_act_d;
      s_q         <= s_d;
    end
  end

endmodule

// File: tb/tb_tf_filter_tdm.sv
// tb/tb_tf_filter_tdm.sv - directed self-checking bench for tf_filter_tdm
module tb_tf_filter_tdm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [17:0] coef_data;
  logic        clear_state;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int y0, y1;
  int held;
  int seen;

  always #5 clk = ~clk;

  tf_filter_tdm dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .clear_state(clear_state)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input int data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data[17:0];
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic accept(input string tag, input int x0, input int x1, input logic clr,
                        input logic we, input logic [2:0] addr, input int data);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    in_data     = {x1[15:0], x0[15:0]};
    in_valid    = 1'b1;
    clear_state = clr;
    coef_we     = we;
    coef_addr   = addr;
    coef_data   = data[17:0];
    tick();
    in_valid    = 1'b0;
    clear_state = 1'b0;
    coef_we     = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int start);
    lat = start;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 6);
    y0 = int'($signed(out_data[15:0]));
    y1 = int'($signed(out_data[31:16]));
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic frame(input string tag, input int x0, input int x1, input logic clr,
                       input int e0, input int e1);
    accept(tag, x0, x1, clr, 1'b0, 3'd0, 0);
    wait_out(tag, 0);
    chk({tag, "_ch0"}, y0, e0);
    chk({tag, "_ch1"}, y1, e1);
    handshake();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; clear_state = 1'b0;
    tick(); tick(); tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Pass-through
    wr(3'd0, 65536);
    frame("pass", 1000, -1234, 1'b0, 1000, -1234);

    // Backpressure: output held, new frame offered but not accepted
    accept("bp", 5, -7, 1'b0, 1'b0, 3'd0, 0);
    wait_out("bp", 0);
    chk("bp_ch0", y0, 5);
    chk("bp_ch1", y1, -7);
    held = int'(out_data);
    in_data = {16'd9, 16'd9};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_held", int'(out_valid), 1);
      chk("bp_data_held", int'(out_data), held);
      chk("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_after_valid", int'(out_valid), 0);
    chk("bp_after_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    chk("bp_no_extra_accept", seen, 0);

    // First-order lowpass on ch0, ch1 silent
    wr(3'd0, 32768);
    wr(3'd3, -32768);
    frame("lp1", 1000, 0, 1'b0, 500, 0);
    frame("lp2", 1000, 0, 1'b0, 750, 0);
    frame("lp3", 1000, 0, 1'b0, 875, 0);
    frame("lp4", 1000, 0, 1'b0, 938, 0);
    frame("lp_clear", 1000, 0, 1'b1, 500, 0);
    frame("lp_after_clear", 1000, 0, 1'b0, 750, 0);

    // Reset in CALC_S aborts the frame and wipes state and coefficients
    accept("rstmid", 1000, 0, 1'b0, 1'b0, 3'd0, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    chk("rstmid_no_output", seen, 0);
    wr(3'd0, 32768);
    wr(3'd3, -32768);
    frame("rstmid_fresh", 1000, 0, 1'b0, 500, 0);

    // Saturation at both rails
    wr(3'd0, 131071);
    wr(3'd3, 0);
    frame("sat", 30000, -30000, 1'b1, 32767, -32768);

    // Coefficient shadowing
    wr(3'd0, 65536);
    accept("shA", 1000, 0, 1'b1, 1'b0, 3'd0, 0);
    wr(3'd0, 32768);
    wait_out("shA", 1);
    chk("shA_ch0", y0, 1000);
    handshake();
    accept("shB", 1000, 0, 1'b0, 1'b1, 3'd0, 65536);
    wait_out("shB", 0);
    chk("shB_ch0", y0, 500);
    handshake();
    wr(3'd5, 12345);
    wr(3'd7, 777);
    frame("shC", 1000, -1000, 1'b0, 1000, -1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
